pattern_sequencer: RTL and testbench
====================================

PATTERN_SEQUENCER -- requirements
Module: pattern_sequencer

Interface
REQ-001 Parameter NUM_PATTERNS, default 7, count of pattern indices 0..NUM_PATTERNS-1 (legal range 1..16).
REQ-002 Parameter ENABLE_MASK, default 16'h007E, bit n=1 marks pattern n selectable.
REQ-003 Parameter INIT_PATTERN, default 1, pattern index after reset.
REQ-004 Parameter FRAMES_PER_PATTERN, default 120, frames per pattern in auto mode (legal range >= 1).
REQ-005 i_Clk  input  1  pixel clock; all logic on its rising edge.
REQ-006 i_Rst_L  input  1  asynchronous reset, active-low.
REQ-007 i_VSync  input  1  vertical sync from the sync generator, high during active rows.
REQ-008 i_Next  input  1  single-cycle request to step forward (already debounced).
REQ-009 i_Prev  input  1  single-cycle request to step backward (already debounced).
REQ-010 i_Auto_En  input  1  level; 1 enables timed auto-advance.
REQ-011 o_Pattern  output  4  registered pattern select, driven to the test pattern generator.
REQ-012 o_Frame_Pulse  output  1  one-cycle pulse per detected frame start.
REQ-013 o_Pending  output  1  high while a manual request awaits the next frame start.

Function
REQ-014 Frame start is the cycle where i_VSync=1 and its one-cycle-delayed copy is 0; o_Frame_Pulse asserts the following cycle, for exactly one cycle.
REQ-015 o_Pattern changes only in the cycle o_Frame_Pulse asserts; it never changes mid-frame.
REQ-016 Request FSM states: IDLE, PEND_NEXT, PEND_PREV; o_Pending=1 in both PEND states.
REQ-017 IDLE: i_Next alone -> PEND_NEXT; i_Prev alone -> PEND_PREV; both in the same cycle -> stay IDLE.
REQ-018 PEND_x: a new i_Next or i_Prev replaces the pending direction (last wins); both in the same cycle -> IDLE (cancel).
REQ-019 At frame start, PEND_NEXT applies a forward step and PEND_PREV a backward step, then -> IDLE; a request arriving in the frame-start cycle itself is held for the next frame start.
REQ-020 Forward step: o_Pattern becomes the next-higher index with its ENABLE_MASK bit set and index < NUM_PATTERNS, wrapping from the top to the lowest such index.
REQ-021 Backward step: o_Pattern becomes the next-lower enabled index, wrapping from the bottom to the highest enabled index.
REQ-022 If the current pattern is the only enabled index, a step leaves o_Pattern unchanged; if no index is enabled, o_Pattern is held at 0.
REQ-023 Frame counter, width $clog2(FRAMES_PER_PATTERN+1); it increments at each frame start while i_Auto_En=1.
REQ-024 While i_Auto_En=1 and the FSM is IDLE, the frame start at which the counter equals FRAMES_PER_PATTERN-1 applies a forward step and clears the counter to 0.
REQ-025 A manual step applied at frame start takes priority over auto-advance, also clears the frame counter, and yields exactly one step.
REQ-026 i_Auto_En=0 holds the frame counter at 0; manual requests still operate.

Reset
REQ-027 While i_Rst_L=0, all state clears asynchronously: o_Pattern=INIT_PATTERN, o_Frame_Pulse=0, o_Pending=0, FSM=IDLE, frame counter=0, delayed VSync=0.
REQ-028 Reset asserted mid-frame with a request pending discards that request; the first i_VSync high after release counts as a frame start.
REQ-029 INIT_PATTERN shall be an enabled index; otherwise the first forward step selects the lowest enabled index above it.

Verification
REQ-030 Reset, i_VSync toggling, no requests, i_Auto_En=0 -> o_Pattern stays 1, o_Frame_Pulse one cycle per rising VSync edge.
REQ-031 i_Next pulse mid-frame -> o_Pending=1 immediately; o_Pattern 1->2 on the next o_Frame_Pulse, o_Pending->0 the same cycle.
REQ-032 Pattern 6, i_Next -> 1 (wrap, 0 masked); pattern 1, i_Prev -> 6.
REQ-033 i_Next then i_Prev in the same frame -> single backward step; i_Next and i_Prev in the same cycle from IDLE -> no change, o_Pending=0.
REQ-034 FRAMES_PER_PATTERN=3, i_Auto_En=1 -> step on every 3rd frame start (1->2->3); an i_Next applied in between restarts the 3-frame count.
REQ-035 i_Rst_L low for 1 cycle with PEND_NEXT at pattern 4 -> o_Pattern=1 asynchronously, o_Pending=0, no step at the following frame start.

Source files
------------

// File: rtl/pattern_sequencer.sv
// Test-pattern selector: manual next/prev requests and timed auto-advance,
// with every pattern change aligned to the start of a video frame.
module pattern_sequencer #(
    parameter int          NUM_PATTERNS       = 7,
    parameter logic [15:0] ENABLE_MASK        = 16'h007E,
    parameter int          INIT_PATTERN       = 1,
    parameter int          FRAMES_PER_PATTERN = 120
) (
    input  logic       i_Clk,
    input  logic       i_Rst_L,
    input  logic       i_VSync,
    input  logic       i_Next,
    input  logic       i_Prev,
    input  logic       i_Auto_En,
    output logic [3:0] o_Pattern,
    output logic       o_Frame_Pulse,
    output logic       o_Pending,
    output logic [1:0] o_State
);

    localparam int          CW         = $clog2(FRAMES_PER_PATTERN + 1);
    localparam logic [16:0] IDX_LIMIT  = (17'd1 << NUM_PATTERNS) - 17'd1;
    localparam logic [15:0] SEL_MASK   = ENABLE_MASK & IDX_LIMIT[15:0];
    localparam logic [CW-1:0] LAST_FRAME = CW'(FRAMES_PER_PATTERN - 1);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        PEND_NEXT = 2'd1,
        PEND_PREV = 2'd2
    } state_t;

    state_t        state;
    state_t        base_state;
    state_t        next_state;
    logic          vsync_d;
    logic          frame_start;
    logic [CW-1:0] frame_cnt;

    assign frame_start = i_VSync & ~vsync_d;
    assign o_State     = state;

    // Circular search over all 16 slots; indices at or above NUM_PATTERNS are
    // masked off, so wrapping lands on the lowest/highest enabled index.
    function automatic logic [3:0] step(input logic [3:0] cur, input logic fwd);
        logic [3:0] idx;
        logic [3:0] res;
        logic       found;
        res   = 4'd0;
        found = 1'b0;
        for (int k = 1; k <= 16; k++) begin
            idx = fwd ? cur + 4'(k) : cur - 4'(k);
            if (!found && SEL_MASK[idx]) begin
                res   = idx;
                found = 1'b1;
            end
        end
        return res;
    endfunction

    // A pending request is consumed at frame start, so requests seen in that
    // same cycle are evaluated as if from IDLE and wait for the next frame.
    always_comb begin
        base_state = frame_start ? IDLE : state;
        next_state = base_state;
        if (i_Next && i_Prev) begin
            next_state = IDLE;
        end else if (i_Next) begin
            next_state = PEND_NEXT;
        end else if (i_Prev) begin
            next_state = PEND_PREV;
        end
    end

    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            state         <= IDLE;
            vsync_d       <= 1'b0;
            frame_cnt     <= '0;
            o_Pattern     <= 4'(INIT_PATTERN);
            o_Frame_Pulse <= 1'b0;
            o_Pending     <= 1'b0;
        end else begin
            vsync_d       <= i_VSync;
            o_Frame_Pulse <= frame_start;
            state         <= next_state;
            o_Pending     <= (next_state != IDLE);
            if (!i_Auto_En) begin
                frame_cnt <= '0;
            end
            if (frame_start) begin
                if (state == PEND_NEXT) begin
                    o_Pattern <= step(o_Pattern, 1'b1);
                    frame_cnt <= '0;
                end else if (state == PEND_PREV) begin
                    o_Pattern <= step(o_Pattern, 1'b0);
                    frame_cnt <= '0;
                end else if (i_Auto_En) begin
                    if (frame_cnt == LAST_FRAME) begin
                        o_Pattern <= step(o_Pattern, 1'b1);
                        frame_cnt <= '0;
                    end else begin
                        frame_cnt <= frame_cnt + CW'(1);
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_pattern_sequencer.sv
// Bench for pattern_sequencer: directed frame scenarios followed by random
// frames/requests, checked each cycle against a list-based reference model.
module tb_pattern_sequencer;

    localparam int          NUM  = 7;
    localparam logic [15:0] MASK = 16'h007E;
    localparam int          INIT = 1;
    localparam int          FPP  = 3;

    logic       i_Clk = 1'b0;
    logic       i_Rst_L;
    logic       i_VSync;
    logic       i_Next;
    logic       i_Prev;
    logic       i_Auto_En;
    logic [3:0] o_Pattern;
    logic       o_Frame_Pulse;
    logic       o_Pending;
    logic [1:0] o_State;

    int total = 0;
    int bad   = 0;

    // reference model state
    int en_list[$];
    int m_pat;
    int m_dir;
    int m_cnt;
    bit m_vsd;
    bit m_pulse;

    pattern_sequencer #(
        .NUM_PATTERNS(NUM),
        .ENABLE_MASK(MASK),
        .INIT_PATTERN(INIT),
        .FRAMES_PER_PATTERN(FPP)
    ) dut (
        .i_Clk(i_Clk),
        .i_Rst_L(i_Rst_L),
        .i_VSync(i_VSync),
        .i_Next(i_Next),
        .i_Prev(i_Prev),
        .i_Auto_En(i_Auto_En),
        .o_Pattern(o_Pattern),
        .o_Frame_Pulse(o_Frame_Pulse),
        .o_Pending(o_Pending),
        .o_State(o_State)
    );

    always #5 i_Clk = ~i_Clk;

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Next/previous enabled index, wrapping around the sorted enabled list.
    function automatic int m_step(input int cur, input int dir);
        if (en_list.size() == 0) return 0;
        if (dir > 0) begin
            foreach (en_list[i]) if (en_list[i] > cur) return en_list[i];
            return en_list[0];
        end
        for (int i = en_list.size() - 1; i >= 0; i--) if (en_list[i] < cur) return en_list[i];
        return en_list[en_list.size() - 1];
    endfunction

    task automatic m_reset();
        m_pat   = INIT;
        m_dir   = 0;
        m_cnt   = 0;
        m_vsd   = 1'b0;
        m_pulse = 1'b0;
    endtask

    task automatic m_edge(input bit vs, input bit nx, input bit pv, input bit au);
        bit fs;
        fs      = vs && !m_vsd;
        m_pulse = fs;
        if (fs) begin
            if (m_dir != 0) begin
                m_pat = m_step(m_pat, m_dir);
                m_cnt = 0;
                m_dir = 0;
            end else if (au) begin
                m_cnt++;
                if (m_cnt == FPP) begin
                    m_pat = m_step(m_pat, 1);
                    m_cnt = 0;
                end
            end
        end
        if (!au) m_cnt = 0;
        if (nx && pv) m_dir = 0;
        else if (nx) m_dir = 1;
        else if (pv) m_dir = -1;
        m_vsd = vs;
    endtask

    task automatic cyc(input bit vs, input bit nx, input bit pv);
        i_VSync = vs;
        i_Next  = nx;
        i_Prev  = pv;
        @(posedge i_Clk);
        m_edge(vs, nx, pv, i_Auto_En);
        #1;
        chk("pattern", o_Pattern, 4'(m_pat));
        chk("frame_pulse", {3'b0, o_Frame_Pulse}, {3'b0, m_pulse});
        chk("pending", {3'b0, o_Pending}, {3'b0, m_dir != 0});
    endtask

    task automatic frame(input int hi, input int lo, input int nx_at, input int pv_at);
        for (int c = 0; c < hi + lo; c++) cyc(c < hi, c == nx_at, c == pv_at);
        i_Next = 1'b0;
        i_Prev = 1'b0;
    endtask

    task automatic do_reset();
        #1;
        i_Rst_L = 1'b0;
        #1;
        m_reset();
        chk("rst_pattern", o_Pattern, 4'(INIT));
        chk("rst_pending", {3'b0, o_Pending}, 4'd0);
        chk("rst_pulse", {3'b0, o_Frame_Pulse}, 4'd0);
        @(posedge i_Clk);
        #2;
        i_Rst_L = 1'b1;
    endtask

    initial begin
        i_Rst_L   = 1'b0;
        i_VSync   = 1'b0;
        i_Next    = 1'b0;
        i_Prev    = 1'b0;
        i_Auto_En = 1'b0;
        for (int i = 0; i < NUM; i++) if (MASK[i]) en_list.push_back(i);
        m_reset();
        repeat (3) @(posedge i_Clk);
        #1;
        chk("init_pattern", o_Pattern, 4'd1);
        chk("init_pending", {3'b0, o_Pending}, 4'd0);
        chk("init_pulse", {3'b0, o_Frame_Pulse}, 4'd0);
        @(negedge i_Clk);
        i_Rst_L = 1'b1;

        // idle frames, no requests, auto off
        repeat (3) frame(5, 3, -1, -1);
        chk("idle_hold", o_Pattern, 4'd1);

        // single next mid-frame
        frame(5, 3, 2, -1);
        chk("next_pending", {3'b0, o_Pending}, 4'd1);
        frame(5, 3, -1, -1);
        chk("next_step", o_Pattern, 4'd2);

        // walk to 6, then wrap forward and backward
        repeat (4) frame(5, 3, 2, -1);
        frame(5, 3, -1, -1);
        chk("walk_to_6", o_Pattern, 4'd6);
        frame(5, 3, 2, -1);
        frame(5, 3, -1, -1);
        chk("wrap_fwd", o_Pattern, 4'd1);
        frame(5, 3, -1, 2);
        frame(5, 3, -1, -1);
        chk("wrap_bwd", o_Pattern, 4'd6);

        // last request wins; simultaneous requests cancel
        frame(5, 3, 1, 3);
        frame(5, 3, -1, -1);
        chk("last_wins", o_Pattern, 4'd5);
        frame(5, 3, 2, 2);
        chk("both_idle", {3'b0, o_Pending}, 4'd0);
        frame(5, 3, -1, -1);
        chk("both_no_step", o_Pattern, 4'd5);

        // request in the frame-start cycle waits one more frame
        frame(5, 3, 0, -1);
        chk("fs_req_held", o_Pattern, 4'd5);
        frame(5, 3, -1, -1);
        chk("fs_req_applied", o_Pattern, 4'd6);

        // auto-advance every third frame start, manual step restarts count
        frame(5, 3, 2, -1);
        frame(5, 3, -1, -1);
        chk("pre_auto", o_Pattern, 4'd1);
        i_Auto_En = 1'b1;
        repeat (3) frame(5, 3, -1, -1);
        chk("auto_1to2", o_Pattern, 4'd2);
        repeat (3) frame(5, 3, -1, -1);
        chk("auto_2to3", o_Pattern, 4'd3);
        frame(5, 3, -1, -1);
        frame(5, 3, 2, -1);
        frame(5, 3, -1, -1);
        chk("auto_manual", o_Pattern, 4'd4);
        frame(5, 3, -1, -1);
        frame(5, 3, -1, -1);
        chk("auto_restart", o_Pattern, 4'd4);
        frame(5, 3, -1, -1);
        chk("auto_after_restart", o_Pattern, 4'd5);
        i_Auto_En = 1'b0;
        frame(5, 3, -1, 2);
        frame(5, 3, -1, -1);
        chk("back_to_4", o_Pattern, 4'd4);

        // reset mid-frame with a pending forward step
        cyc(1'b1, 1'b0, 1'b0);
        cyc(1'b1, 1'b1, 1'b0);
        cyc(1'b1, 1'b0, 1'b0);
        do_reset();
        repeat (3) cyc(1'b1, 1'b0, 1'b0);
        repeat (3) cyc(1'b0, 1'b0, 1'b0);
        chk("post_reset_pattern", o_Pattern, 4'd1);
        chk("post_reset_pending", {3'b0, o_Pending}, 4'd0);

        // random frames, requests, auto toggling and occasional resets
        for (int f = 0; f < 150; f++) begin
            int hi;
            int lo;
            if ($urandom_range(0, 3) == 0) i_Auto_En = ~i_Auto_En;
            hi = $urandom_range(2, 8);
            lo = $urandom_range(1, 4);
            for (int c = 0; c < hi + lo; c++) begin
                cyc(c < hi, $urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0);
                if ($urandom_range(0, 299) == 0) do_reset();
            end
        end
        i_Next = 1'b0;
        i_Prev = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
